// File: rtl/sdram_write_arbiter.sv
// sdram_write_arbiter: round-robin arbiter funnelling PORTS single-entry write
// slots onto one SDRAM write port, with per-port overrun flags and a watchdog
// that aborts a write whose mem_wr_done never arrives.
module sdram_write_arbiter #(
  parameter int unsigned PORTS   = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PORTS-1:0]      port_wr_request,
  input  logic [23*PORTS-1:0]   port_wr_address,
  input  logic [32*PORTS-1:0]   port_wr_data,
  input  logic [4*PORTS-1:0]    port_wr_mask,
  output logic [PORTS-1:0]      port_wr_done,
  output logic [22:0]           mem_wr_address,
  output logic                  mem_wr_request,
  output logic [31:0]           mem_wr_data,
  output logic [3:0]            mem_wr_mask,
  input  logic                  mem_wr_done,
  output logic [PORTS-1:0]      overrun,
  output logic                  timeout
);

  localparam int unsigned AW  = 23;
  localparam int unsigned DW  = 32;
  localparam int unsigned MW  = 4;
  localparam int unsigned WDW = 16;
  localparam int unsigned GW  = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [GW-1:0]  LAST_PORT = GW'(PORTS - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT);

  // Registered state
  logic [0:0]     state;
  logic [PORTS-1:0] pending;
  logic [GW-1:0]  last_grant;
  logic [GW-1:0]  grant;
  logic [WDW-1:0] watchdog;
  logic [AW-1:0]  slot_addr [PORTS];
  logic [DW-1:0]  slot_data [PORTS];
  logic [MW-1:0]  slot_mask [PORTS];

  // Next-state values
  logic [0:0]     state_d;
  logic [PORTS-1:0] pending_d;
  logic [GW-1:0]  last_grant_d;
  logic [GW-1:0]  grant_d;
  logic [WDW-1:0] watchdog_d;
  logic [AW-1:0]  slot_addr_d [PORTS];
  logic [DW-1:0]  slot_data_d [PORTS];
  logic [MW-1:0]  slot_mask_d [PORTS];
  logic [PORTS-1:0] port_wr_done_d;
  logic [AW-1:0]  mem_wr_address_d;
  logic           mem_wr_request_d;
  logic [DW-1:0]  mem_wr_data_d;
  logic [MW-1:0]  mem_wr_mask_d;
  logic [PORTS-1:0] overrun_d;
  logic           timeout_d;

  // Round-robin pick
  logic           sel_valid;
  logic [GW-1:0]  sel;

  // Round-robin search starting one past the last completed grant
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_valid = 1'b0;
    sel       = '0;
    for (int unsigned k = 1; k <= PORTS; k++) begin
      idx = (32'(last_grant) + k) % PORTS;
      if (!sel_valid && pending[idx]) begin
        sel_valid = 1'b1;
        sel       = GW'(idx);
      end
    end
  end

  // Next-state and output logic for the IDLE/WAIT controller and slot capture
  always_comb begin
    state_d          = state;
    pending_d        = pending;
    last_grant_d     = last_grant;
    grant_d          = grant;
    watchdog_d       = watchdog;
    slot_addr_d      = slot_addr;
    slot_data_d      = slot_data;
    slot_mask_d      = slot_mask;
    port_wr_done_d   = '0;
    mem_wr_address_d = mem_wr_address;
    mem_wr_request_d = 1'b0;
    mem_wr_data_d    = mem_wr_data;
    mem_wr_mask_d    = mem_wr_mask;
    overrun_d        = overrun;
    timeout_d        = timeout;

    case (state)
      IDLE: begin
        if (sel_valid) begin
          mem_wr_address_d = slot_addr[sel];
          mem_wr_data_d    = slot_data[sel];
          mem_wr_mask_d    = slot_mask[sel];
          mem_wr_request_d = 1'b1;
          grant_d          = sel;
          watchdog_d       = '0;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        watchdog_d = watchdog + WDW'(1);
        // A real completion wins over a watchdog expiry on the same edge
        if (mem_wr_done || (watchdog_d == WD_LIMIT)) begin
          if (!mem_wr_done) begin
            timeout_d = 1'b1;
          end
          port_wr_done_d[grant] = 1'b1;
          pending_d[grant]      = 1'b0;
          last_grant_d          = grant;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot freed on this edge may accept a new request without an overrun
    for (int i = 0; i < int'(PORTS); i++) begin
      if (port_wr_request[i]) begin
        if (!pending_d[i]) begin
          pending_d[i]   = 1'b1;
          slot_addr_d[i] = port_wr_address[AW*i +: AW];
          slot_data_d[i] = port_wr_data[DW*i +: DW];
          slot_mask_d[i] = port_wr_mask[MW*i +: MW];
        end else begin
          overrun_d[i] = 1'b1;
        end
      end
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pending        <= '0;
      last_grant     <= LAST_PORT;
      grant          <= '0;
      watchdog       <= '0;
      for (int i = 0; i < int'(PORTS); i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
        slot_mask[i] <= '0;
      end
      port_wr_done   <= '0;
      mem_wr_address <= '0;
      mem_wr_request <= 1'b0;
      mem_wr_data    <= '0;
      mem_wr_mask    <= 4'b1111;
      overrun        <= '0;
      timeout        <= 1'b0;
    end else begin
      state          <= state_d;
      pending        <= pending_d;
      last_grant     <= last_grant_d;
      grant          <= grant_d;
      watchdog       <= watchdog_d;
      slot_addr      <= slot_addr_d;
      slot_data      <= slot_data_d;
      slot_mask      <= slot_mask_d;
      port_wr_done   <= port_wr_done_d;
      mem_wr_address <= mem_wr_address_d;
      mem_wr_request <= mem_wr_request_d;
      mem_wr_data    <= mem_wr_data_d;
      mem_wr_mask    <= mem_wr_mask_d;
      overrun        <= overrun_d;
      timeout        <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Directed bench for sdram_write_arbiter: single write, contention, fairness,
// overrun, watchdog abort and reset during WAIT.
module tb_sdram_write_arbiter;

  localparam int unsigned PORTS = 3;
  localparam int unsigned TMO   = 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [PORTS-1:0]    port_wr_request;
  logic [23*PORTS-1:0] port_wr_address;
  logic [32*PORTS-1:0] port_wr_data;
  logic [4*PORTS-1:0]  port_wr_mask;
  logic [PORTS-1:0]    port_wr_done;
  logic [22:0]         mem_wr_address;
  logic                mem_wr_request;
  logic [31:0]         mem_wr_data;
  logic [3:0]          mem_wr_mask;
  logic                mem_wr_done = 1'b0;
  logic [PORTS-1:0]    overrun;
  logic                timeout;

  sdram_write_arbiter #(.PORTS(PORTS), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .port_wr_request (port_wr_request),
    .port_wr_address (port_wr_address),
    .port_wr_data    (port_wr_data),
    .port_wr_mask    (port_wr_mask),
    .port_wr_done    (port_wr_done),
    .mem_wr_address  (mem_wr_address),
    .mem_wr_request  (mem_wr_request),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_mask     (mem_wr_mask),
    .mem_wr_done     (mem_wr_done),
    .overrun         (overrun),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int checks   = 0;
  int failures = 0;

  // Logs of observed memory requests and port completions
  logic [22:0]      rq_addr [$];
  logic [31:0]      rq_data [$];
  logic [3:0]       rq_mask [$];
  int               rq_cyc  [$];
  logic [PORTS-1:0] dn_val  [$];
  int               dn_cyc  [$];

  int resp_delay = 0;  // 0: memory never answers
  int resp_cnt   = 0;
  int fire_cyc   = 0;

  // Memory responder and monitor, sampling on the falling edge
  always @(negedge clk) begin
    mem_wr_done = 1'b0;
    if (!reset_n) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) mem_wr_done = 1'b1;
      end
      if (mem_wr_request === 1'b1) begin
        rq_addr.push_back(mem_wr_address);
        rq_data.push_back(mem_wr_data);
        rq_mask.push_back(mem_wr_mask);
        rq_cyc.push_back(cycle);
        if (resp_delay > 0) resp_cnt = resp_delay;
      end
      if (port_wr_done !== '0) begin
        dn_val.push_back(port_wr_done);
        dn_cyc.push_back(cycle);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rq_addr.delete(); rq_data.delete(); rq_mask.delete(); rq_cyc.delete();
    dn_val.delete(); dn_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    port_wr_request = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic set_port(input int p, input logic [22:0] a, input logic [31:0] d, input logic [3:0] m);
    port_wr_address[23*p +: 23] = a;
    port_wr_data[32*p +: 32]    = d;
    port_wr_mask[4*p +: 4]      = m;
  endtask

  // One-cycle request pulse; returns on the falling edge after the capture edge
  task automatic fire(input logic [PORTS-1:0] which);
    @(negedge clk);
    port_wr_request = which;
    fire_cyc = cycle;
    @(negedge clk);
    port_wr_request = '0;
  endtask

  task automatic wait_dones(input int n, input string tag);
    int budget;
    budget = 60;
    while (dn_val.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_wait"}, 32'(dn_val.size() >= n), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n         = 1'b0;
    port_wr_request = '0;
    port_wr_address = '0;
    port_wr_data    = '0;
    port_wr_mask    = '0;

    // Reset values
    #12;
    check("rst_mem_req",  32'(mem_wr_request), 32'd0);
    check("rst_mem_addr", 32'(mem_wr_address), 32'd0);
    check("rst_mem_data", mem_wr_data, 32'd0);
    check("rst_mem_mask", 32'(mem_wr_mask), 32'hF);
    check("rst_done",     32'(port_wr_done), 32'd0);
    check("rst_overrun",  32'(overrun), 32'd0);
    check("rst_timeout",  32'(timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();

    // Single write on port 1, memory answers 3 cycles after the grant
    resp_delay = 3;
    set_port(1, 23'h000140, 32'hF0000041, 4'h3);
    fire(3'b010);
    wait_dones(1, "s1");
    check("s1_req_count", 32'(rq_addr.size()), 32'd1);
    check("s1_addr",      32'(rq_addr[0]), 32'h000140);
    check("s1_data",      rq_data[0], 32'hF0000041);
    check("s1_mask",      32'(rq_mask[0]), 32'h3);
    check("s1_grant_lat", 32'(rq_cyc[0] - fire_cyc), 32'd2);
    check("s1_done_lat",  32'(dn_cyc[0] - rq_cyc[0]), 32'd4);
    check("s1_done_val",  32'(dn_val[0]), 32'b010);
    check("s1_done_count", 32'(dn_val.size()), 32'd1);

    // Contention: all three ports on one edge right after reset
    do_reset();
    resp_delay = 1;
    set_port(0, 23'h000100, 32'h11111111, 4'h1);
    set_port(1, 23'h000200, 32'h22222222, 4'h2);
    set_port(2, 23'h000300, 32'h33333333, 4'h4);
    fire(3'b111);
    wait_dones(3, "s2");
    check("s2_req_count", 32'(rq_addr.size()), 32'd3);
    check("s2_addr0", 32'(rq_addr[0]), 32'h100);
    check("s2_addr1", 32'(rq_addr[1]), 32'h200);
    check("s2_addr2", 32'(rq_addr[2]), 32'h300);
    check("s2_data2", rq_data[2], 32'h33333333);
    check("s2_done0", 32'(dn_val[0]), 32'b001);
    check("s2_done1", 32'(dn_val[1]), 32'b010);
    check("s2_done2", 32'(dn_val[2]), 32'b100);
    check("s2_done_count", 32'(dn_val.size()), 32'd3);
    check("s2_min_lat",  32'(dn_cyc[0] - rq_cyc[0]), 32'd2);
    check("s2_gap01",    32'(rq_cyc[1] - dn_cyc[0]), 32'd1);
    check("s2_gap12",    32'(rq_cyc[2] - dn_cyc[1]), 32'd1);
    check("s2_overrun",  32'(overrun), 32'd0);

    // Fairness: port 0 re-requests on the edge its done issues, port 2 waits
    do_reset();
    resp_delay = 2;
    set_port(0, 23'h0000A1, 32'hA0A0A0A1, 4'h0);
    set_port(2, 23'h0002C2, 32'hC2C2C2C2, 4'hF);
    fire(3'b101);
    repeat (3) @(negedge clk);
    set_port(0, 23'h0000A2, 32'hA0A0A0A2, 4'h8);
    port_wr_request = 3'b001;
    @(negedge clk);
    port_wr_request = '0;
    wait_dones(3, "s3");
    check("s3_req_count", 32'(rq_addr.size()), 32'd3);
    check("s3_first",  32'(rq_addr[0]), 32'h0A1);
    check("s3_second", 32'(rq_addr[1]), 32'h2C2);
    check("s3_third",  32'(rq_addr[2]), 32'h0A2);
    check("s3_third_data", rq_data[2], 32'hA0A0A0A2);
    check("s3_done_lat", 32'(dn_cyc[0] - rq_cyc[0]), 32'd3);
    check("s3_done1", 32'(dn_val[1]), 32'b100);
    check("s3_overrun", 32'(overrun), 32'd0);

    // Overrun: port 2 requests twice before its done
    do_reset();
    resp_delay = 3;
    set_port(2, 23'h000222, 32'hDEAD0001, 4'h5);
    fire(3'b100);
    set_port(2, 23'h000333, 32'hBEEF0002, 4'hA);
    fire(3'b100);
    wait_dones(1, "s4");
    repeat (6) @(negedge clk);
    check("s4_overrun",   32'(overrun), 32'b100);
    check("s4_req_count", 32'(rq_addr.size()), 32'd1);
    check("s4_addr",      32'(rq_addr[0]), 32'h222);
    check("s4_data",      rq_data[0], 32'hDEAD0001);
    check("s4_mask",      32'(rq_mask[0]), 32'h5);
    check("s4_done_count", 32'(dn_val.size()), 32'd1);

    // Watchdog: memory never answers
    do_reset();
    resp_delay = 0;
    check("s5_timeout_pre", 32'(timeout), 32'd0);
    set_port(1, 23'h000055, 32'h55555555, 4'h6);
    fire(3'b010);
    wait_dones(1, "s5");
    check("s5_timeout",  32'(timeout), 32'd1);
    check("s5_done_val", 32'(dn_val[0]), 32'b010);
    check("s5_abort_lat", 32'(dn_cyc[0] - rq_cyc[0]), 32'(TMO));
    resp_delay = 1;
    set_port(0, 23'h000066, 32'h66666666, 4'h9);
    fire(3'b001);
    wait_dones(2, "s5b");
    check("s5_next_grant", 32'(rq_addr[1]), 32'h066);
    check("s5_next_lat",  32'(rq_cyc[1] - fire_cyc), 32'd2);
    check("s5_next_done", 32'(dn_val[1]), 32'b001);
    check("s5_sticky",    32'(timeout), 32'd1);

    // Reset asserted while WAIT holds a grant
    do_reset();
    resp_delay = 0;
    set_port(0, 23'h000077, 32'h77777777, 4'h0);
    fire(3'b001);
    @(negedge clk);
    #2;
    check("s6_req_before", 32'(mem_wr_request), 32'd1);
    reset_n = 1'b0;
    #1;
    check("s6_req",  32'(mem_wr_request), 32'd0);
    check("s6_addr", 32'(mem_wr_address), 32'd0);
    check("s6_data", mem_wr_data, 32'd0);
    check("s6_mask", 32'(mem_wr_mask), 32'hF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("s6_no_done",   32'(dn_val.size()), 32'd0);
    check("s6_req_count", 32'(rq_addr.size()), 32'd1);
    check("s6_timeout",   32'(timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
